// File: rtl/sbox_cfg_loader.sv
// sbox_cfg_loader: serial frame loader with legality check and atomic commit.
// Define SBOX_CFG_PARITY_EN for a trailing even-parity bit per frame.
module sbox_cfg_loader #(
  parameter int NUM_TB = 5,
  parameter int NUM_LR = 4,
  parameter int ENTRY_W = 6,
  localparam int NUM_ENTRIES = 2*NUM_TB+2*NUM_LR,
  localparam int CFG_W = ENTRY_W*NUM_ENTRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       err_entry,
  output logic [CFG_W-1:0] cfg_active
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [4:0] K_BOT = 5'(NUM_TB);
  localparam logic [4:0] K_LFT = 5'(2*NUM_TB);
  localparam logic [4:0] K_RGT = 5'(2*NUM_TB+NUM_LR);
  localparam logic [4:0] LAST_ENT = 5'(NUM_ENTRIES-1);
  localparam logic [4:0] PAR_SLOT = 5'(NUM_ENTRIES);
  localparam logic [3:0] TB4 = 4'(NUM_TB);
  localparam logic [3:0] LR4 = 4'(NUM_LR);

  state_t state, nxt;

  logic [CFG_W-1:0]   shadow;
  logic [ENTRY_W-2:0] cur;
  logic [2:0]         bit_cnt;
  logic [4:0]         ent_cnt;
  logic [ENTRY_W-1:0] ent;
  logic               ent_bad;
  logic               xfer;
  logic               last_bit;
`ifdef SBOX_CFG_PARITY_EN
  logic               par;
`endif

  function automatic logic entry_bad(
    input logic [4:0] k,
    input logic [5:0] e
  );
    logic [2:0] own_s;
    logic [4:0] own_i;
    logic       bad;
    own_s = 3'd2;
    own_i = k - K_RGT;
    unique case (1'b1)
      (k < K_BOT): begin
        own_s = 3'd1;
        own_i = k;
      end
      (k >= K_BOT && k < K_LFT): begin
        own_s = 3'd3;
        own_i = k - K_BOT;
      end
      (k >= K_LFT && k < K_RGT): begin
        own_s = 3'd4;
        own_i = k - K_LFT;
      end
      default: ;
    endcase
    bad = 1'b0;
    unique case (e[2:0])
      3'd0: bad = 1'b0;
      3'd1, 3'd3: bad = ({1'b0, e[5:3]} >= TB4);
      3'd2, 3'd4: bad = ({1'b0, e[5:3]} >= LR4);
      default: bad = 1'b1;
    endcase
    // selecting its own pin closes a loop through the mux
    if (e[2:0] == own_s && {2'b00, e[5:3]} == own_i)
      bad = 1'b1;
    return bad;
  endfunction

  assign ent = {cur, bit_data};
  assign ent_bad = entry_bad(ent_cnt, ent);
  assign xfer = bit_valid && (state == SHIFT);

  always_comb begin
    bit_ready = 1'b0;
    busy = 1'b0;
`ifdef SBOX_CFG_PARITY_EN
    last_bit = (ent_cnt == PAR_SLOT);
`else
    last_bit = (ent_cnt == LAST_ENT) &&
               (bit_cnt == 3'd5);
`endif
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = SHIFT;
      end
      SHIFT: begin
        bit_ready = 1'b1;
        busy = 1'b1;
        if (abort) nxt = IDLE;
        else if (bit_valid && last_bit) nxt = COMMIT;
      end
      COMMIT: begin
        busy = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cur <= '0;
      bit_cnt <= '0;
      ent_cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_entry <= '0;
      cfg_active <= '0;
`ifdef SBOX_CFG_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          shadow <= '0;
          cur <= '0;
          bit_cnt <= '0;
          ent_cnt <= '0;
          err <= 1'b0;
          err_entry <= '0;
`ifdef SBOX_CFG_PARITY_EN
          par <= 1'b0;
`endif
        end else if (clear) begin
          cfg_active <= '0;
        end
      end
      if (xfer && !abort) begin
`ifdef SBOX_CFG_PARITY_EN
        par <= par ^ bit_data;
        if (ent_cnt == PAR_SLOT) begin
          if ((par ^ bit_data) && !err) begin
            err <= 1'b1;
            err_entry <= PAR_SLOT;
          end
        end else
`endif
        if (bit_cnt == 3'd5) begin
          bit_cnt <= '0;
          ent_cnt <= ent_cnt + 5'd1;
          for (int k = 0; k < NUM_ENTRIES; k++)
            if (ent_cnt == 5'(k))
              shadow[k*ENTRY_W +: ENTRY_W] <= ent;
          if (ent_bad && !err) begin
            err <= 1'b1;
            err_entry <= ent_cnt;
          end
        end else begin
          cur <= ent[ENTRY_W-2:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (state == COMMIT && !abort && !err) begin
        cfg_active <= shadow;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// tb_sbox_cfg_loader: table vectors, corner sequences and random frames
// checked against a pin-table legality model.
module tb_sbox_cfg_loader;
  localparam int NE = 18;
  localparam int CW = 108;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic clear = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;
  logic bit_ready, busy, done, err;
  logic [4:0] err_entry;
  logic [CW-1:0] cfg_active;

  int checks = 0;
  int errors = 0;

  logic [5:0] frame [NE];
  logic [CW-1:0] exp_cfg = '0;
  int pin_side [NE];
  int pin_idx [NE];
  bit me;
  int mee;

  typedef struct {
    int k;
    logic [5:0] val;
    bit e;
    int ee;
  } vec_t;
  vec_t vt [12];

  sbox_cfg_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .clear(clear),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .bit_ready(bit_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .err_entry(err_entry),
    .cfg_active(cfg_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(output bit e, output int ee);
    int s, i;
    bit bad;
    e = 0;
    ee = 0;
    for (int k = 0; k < NE; k++) begin
      s = int'(frame[k][2:0]);
      i = int'(frame[k][5:3]);
      bad = (s > 4) ||
            ((s == 1 || s == 3) && i >= 5) ||
            ((s == 2 || s == 4) && i >= 4) ||
            (s == pin_side[k] && i == pin_idx[k]);
      if (bad && !e) begin
        e = 1;
        ee = k;
      end
    end
  endfunction

  function automatic logic [CW-1:0] pack();
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < NE; k++) v[k*6 +: 6] = frame[k];
    return v;
  endfunction

  task automatic push_bit(input logic b);
    int g = 0;
    bit_valid = 1'b1;
    bit_data = b;
    while (!bit_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bit_ready) begin
      checks++;
      errors++;
      $display("FAIL bit_ready_timeout act=0 exp=1");
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic shift_frame(input int nbits, input int gap, input bit pflip);
    int n = 0;
    logic p = 1'b0;
    for (int k = 0; k < NE; k++) p = p ^ (^frame[k]);
    for (int k = 0; k < NE; k++)
      for (int b = 5; b >= 0; b--) begin
        if (n == nbits) return;
        if (gap > 0 && (n % gap) == gap / 2) begin
          start = 1'b1;
          repeat (3) @(negedge clk);
          start = 1'b0;
        end
        push_bit(frame[k][b]);
        n++;
      end
`ifdef SBOX_CFG_PARITY_EN
    if (n < nbits) push_bit(p ^ pflip);
`else
    if (pflip && p) n = n + 0;
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clr", err, 0);
  endtask

  task automatic full_frame(input int gap, input bit pflip,
                            input bit e_in, input int ee_in);
    bit e;
    int ee;
    e = e_in;
    ee = ee_in;
`ifdef SBOX_CFG_PARITY_EN
    if (pflip && !e) begin
      e = 1;
      ee = 18;
    end
`endif
    do_start();
    shift_frame(1000, gap, pflip);
    chk("commit_busy", busy, 1);
    chk("commit_no_early_done", done, 0);
    @(negedge clk);
    chk("done", done, !e);
    chk("err", err, e);
    if (e) chk("err_entry", err_entry, ee);
    if (!e) exp_cfg = pack();
    chk("cfg", cfg_active, exp_cfg);
    chk("idle_after", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    for (int j = 0; j < 5; j++) begin
      pin_side[j] = 1;
      pin_idx[j] = j;
      pin_side[5+j] = 3;
      pin_idx[5+j] = j;
    end
    for (int j = 0; j < 4; j++) begin
      pin_side[10+j] = 4;
      pin_idx[10+j] = j;
      pin_side[14+j] = 2;
      pin_idx[14+j] = j;
    end
    vt[0]  = '{0,  6'b001_010, 0, 0};
    vt[1]  = '{10, 6'b101_010, 1, 10};
    vt[2]  = '{8,  6'b011_011, 1, 8};
    vt[3]  = '{5,  6'b100_001, 0, 0};
    vt[4]  = '{3,  6'b000_101, 1, 3};
    vt[5]  = '{17, 6'b111_000, 0, 0};
    vt[6]  = '{14, 6'b000_010, 1, 14};
    vt[7]  = '{12, 6'b101_001, 1, 12};
    vt[8]  = '{4,  6'b100_001, 1, 4};
    vt[9]  = '{13, 6'b011_100, 1, 13};
    vt[10] = '{9,  6'b011_100, 0, 0};
    vt[11] = '{16, 6'b011_010, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_ready", bit_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_entry", err_entry, 0);
    chk("rst_cfg", cfg_active, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < NE; k++) frame[k] = 6'd0;
      frame[vt[v].k] = vt[v].val;
      full_frame(0, 0, vt[v].e, vt[v].ee);
    end

    for (int k = 0; k < NE; k++) frame[k] = 6'd0;
    frame[2] = 6'b111_111;
    frame[6] = 6'b001_011;
    full_frame(0, 0, 1, 2);

    for (int k = 0; k < NE; k++) frame[k] = 6'd0;
    frame[1] = 6'b000_011;
    do_start();
    shift_frame(50, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    chk("abort_cfg", cfg_active, exp_cfg);

    do_start();
    shift_frame(1000, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_commit_done", done, 0);
    chk("abort_commit_cfg", cfg_active, exp_cfg);

    full_frame(0, 0, 0, 0);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    chk("start_over_clear_busy", busy, 1);
    chk("start_over_clear_cfg", cfg_active, exp_cfg);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_cfg = '0;
    chk("clear_cfg", cfg_active, exp_cfg);

    for (int k = 0; k < NE; k++) frame[k] = 6'd0;
    frame[0] = 6'b010_011;
    frame[7] = 6'b001_001;
    frame[11] = 6'b011_010;
    frame[15] = 6'b010_100;
    full_frame(7, 0, 0, 0);

    for (int k = 0; k < NE; k++) frame[k] = 6'd0;
    frame[0] = 6'h0A;
    full_frame(0, 0, 0, 0);
    do_start();
    shift_frame(70, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg", cfg_active, 0);
    chk("arst_ready", bit_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cfg = '0;
    @(negedge clk);

`ifdef SBOX_CFG_PARITY_EN
    for (int k = 0; k < NE; k++) frame[k] = 6'd0;
    frame[3] = 6'b001_011;
    frame[9] = 6'b000_100;
    full_frame(0, 1, 0, 0);
    full_frame(0, 0, 0, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      bit pf;
      for (int k = 0; k < NE; k++)
        if ($urandom_range(0, 5) == 0)
          frame[k] = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
        else
          frame[k] = 6'd0;
      model(me, mee);
`ifdef SBOX_CFG_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`else
      pf = 0;
`endif
      full_frame(($urandom_range(0, 3) == 0) ? 5 : 0, pf, me, mee);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_cfg_loader.md
Name: sbox_cfg_loader

Overview:
- Serial configuration loader and commit controller for the 6x6 routing switch box.
- Shifts in one full bitstream frame of per-pin select entries and checks each entry for legality.
- Atomically commits the frame to the flat config bus driving the switch box mux selects, so the switch box never sees a partial or illegal configuration.
- Sits between the fabric configuration chain and each switch-box instance.

Parameters:
- NUM_TB, 5, pins per top/bottom edge.
- NUM_LR, 4, pins per left/right edge.
- ENTRY_W, 6, bits per entry: [2:0] side code, [5:3] source index.
- NUM_ENTRIES (derived), 2*NUM_TB+2*NUM_LR = 18.
- CFG_W (derived), ENTRY_W*NUM_ENTRIES = 108.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin new frame; honoured only in IDLE.
- abort  in  1  discard frame in progress.
- clear  in  1  zero cfg_active; honoured only in IDLE.
- bit_valid  in  1  serial bit offered.
- bit_data  in  1  serial bit, MSB of each entry first.
- bit_ready  out  1  loader accepts bit; transfer when bit_valid && bit_ready.
- busy  out  1  high in SHIFT or COMMIT.
- done  out  1  one-cycle pulse on successful commit.
- err  out  1  sticky frame error; cleared by next accepted start.
- err_entry  out  5  index of first failing entry; 18 = parity failure.
- cfg_active  out  CFG_W  committed config; entry k at [6k+5:6k].

Behaviour:
- Reset (async, rst_n=0): state IDLE; cfg_active=0 (all switch-box pins high-Z); shadow=0; bit_ready=0, busy=0, done=0, err=0, err_entry=0; counters 0.
- Entry order k:
  - 0..4 top[0..4]
  - 5..9 bottom[0..4]
  - 10..13 left[0..3]
  - 14..17 right[0..3]
- Side codes: 0 = high-Z; 1 = top; 2 = right; 3 = bottom; 4 = left.
- IDLE:
  - bit_ready=0.
  - start=1: clear shadow, bit/entry counters and err; go to SHIFT next cycle.
  - clear=1 (start=0): cfg_active<=0.
  - start and clear both high: start wins; clear is ignored.
- SHIFT:
  - bit_ready=1.
  - Each accepted bit shifts into the current entry.
  - On the 6th bit of an entry, write it to shadow[k] and run the legality check.
  - The first illegal entry sets err and latches err_entry=k; later errors do not overwrite it.
  - Shifting continues to consume the whole frame.
  - The cycle after the last payload bit (or parity bit when enabled) is accepted, go to COMMIT.
  - bit_valid=0 stalls with no timeout.
- Legality check on an entry, illegal if any of:
  - side code 5..7;
  - side 1/3 with index >= NUM_TB;
  - side 2/4 with index >= NUM_LR;
  - self-select, i.e. entry drives its own pin (e.g. top[2] selecting top index 2). This is a combinational loop in the switch box.
  - Side 0 is legal with any index.
- COMMIT (one cycle):
  - If err=0: at the clock edge, cfg_active<=shadow and done<=1.
  - If err=1: cfg_active is unchanged and done stays 0.
  - Either way, return to IDLE.
- Latency: last bit accepted in cycle N, COMMIT in N+1, cfg_active updated and done high in N+2 only.
- abort:
  - In SHIFT or COMMIT, go to IDLE next edge; shadow is discarded, cfg_active is unchanged, no done, err is unchanged.
  - Abort has priority over commit in the same cycle.
  - Ignored in IDLE.
- start while busy: ignored.
- Reset mid-frame: everything, including cfg_active, returns to zero immediately.
- Bit counter is 0..5 and wraps per entry. Entry counter is 0..NUM_ENTRIES-1, plus the parity slot when enabled.

Optional Feature:
- Macro SBOX_CFG_PARITY_EN.
- Defined:
  - Frame carries one extra trailing bit after 108 payload bits, so SHIFT accepts 109 bits.
  - Even parity over payload plus parity bit must be 0.
  - On mismatch, set err with err_entry=18 if no earlier entry error was latched.
  - COMMIT is then suppressed.
- Undefined: frame is exactly 108 bits, no parity logic, err_entry never 18.

Test Plan:
- Reset, then start, then 108 bits with top[0]=6'b001_010 (right[1]) and all others 0. Required: done pulse 2 cycles after last bit; cfg_active[5:0]=6'h0A; rest 0; err=0.
- Frame with entry 10 (left[0]) = 6'b101_010 (right index 5). Required: err=1, err_entry=10, no done, cfg_active keeps the previous value.
- Frame with bottom[3] (k=8) = 6'b011_011 (self-select). Required: err=1, err_entry=8. A subsequent clean start then clears err and commits.
- Abort after 50 bits; start and clear asserted together in IDLE; bit_valid gaps of 3 cycles mid-entry. Required: no commit after abort; start wins over clear; gaps lose no bits.
- Assert rst_n=0 at bit 70 of a frame after a prior commit of 0xA. Required: cfg_active=0 asynchronously, state IDLE, bit_ready=0.
- With SBOX_CFG_PARITY_EN: valid payload with wrong parity bit. Required: err_entry=18, no done. Same payload with correct parity: commit succeeds.
